// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared forwarding select encodings and default register index width
package hazard_scoreboard_pkg;
  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: pipeline-side signals of the hazard unit; master is the datapath, slave the hazard unit
interface hazard_scoreboard_if import hazard_scoreboard_pkg::*; #(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int STALL_CNT_W = 16
);
  logic [REG_ADDR_W-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, LongRdW;
  logic RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, LongIssueE, LongDoneW, DmemReadyM;
  logic [1:0] forwardaE, forwardbE;
  logic stallF, stallD, stallE, stallM, flushD, flushE;
  logic [2**REG_ADDR_W-1:0] sb_busy;
  logic [STALL_CNT_W-1:0] stall_cnt;
  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, LongRdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, LongIssueE, LongDoneW, DmemReadyM,
    input forwardaE, forwardbE, stallF, stallD, stallE, stallM, flushD, flushE, sb_busy, stall_cnt
  );
  modport slave (
    input rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, LongRdW,
    input RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, LongIssueE, LongDoneW, DmemReadyM,
    output forwardaE, forwardbE, stallF, stallD, stallE, stallM, flushD, flushE, sb_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_reg_scoreboard.sv
// reg_scoreboard: per-register busy bits and in-flight counter for long-latency writers
module reg_scoreboard import hazard_scoreboard_pkg::*; #(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_i,
  input  logic [REG_ADDR_W-1:0]      issue_rd_i,
  input  logic                       done_i,
  input  logic [REG_ADDR_W-1:0]      done_rd_i,
  output logic [2**REG_ADDR_W-1:0]   busy_o,
  output logic                       full_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [2**REG_ADDR_W-1:0] busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done;
  // set is applied after clear so a same-register issue/done pair leaves the bit busy
  always_comb begin
    done = done_i && busy_q[done_rd_i];
    busy_d = busy_q;
    if (done) busy_d[done_rd_i] = 1'b0;
    if (issue_i) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = cnt_q + CW'(issue_i) - CW'(done);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy_o = busy_q;
  assign full_o = cnt_q == CW'(MAX_OUTSTANDING);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding, stall and flush control for the 5-stage pipeline with long-op scoreboard
module hazard_scoreboard import hazard_scoreboard_pkg::*; #(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STALL_CNT_W = 16
) (
  input logic clk,
  input logic reset,
  hazard_scoreboard_if.slave hz
);
  logic [2**REG_ADDR_W-1:0] busy;
  logic full, memstall, lwstall, sbstall, structstall, stall_e, stall_d, issue;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  function automatic logic [1:0] fwd(input logic [REG_ADDR_W-1:0] rs, rd_m, rd_w, input logic we_m, we_w);
    return (rs == '0) ? FWD_REG : (we_m && rs == rd_m) ? FWD_M : (we_w && rs == rd_w) ? FWD_W : FWD_REG;
  endfunction
  assign hz.forwardaE = fwd(hz.rs1E, hz.rdM, hz.rdW, hz.RegWriteM, hz.RegWriteW);
  assign hz.forwardbE = fwd(hz.rs2E, hz.rdM, hz.rdW, hz.RegWriteM, hz.RegWriteW);
  assign memstall = ~hz.DmemReadyM;
  assign lwstall = hz.ResultSrcE0 && hz.rdE != '0 && (hz.rdE == hz.rs1D || hz.rdE == hz.rs2D);
  assign sbstall = (busy[hz.rs1D] && hz.rs1D != '0) || (busy[hz.rs2D] && hz.rs2D != '0);
  // E must also hold when any writer in E targets a register a long op still owns (WAW)
  assign structstall = (hz.LongIssueE && (full || busy[hz.rdE]))
                    || ((hz.LongIssueE || hz.ResultSrcE0) && busy[hz.rdE] && hz.rdE != '0);
  assign stall_e = memstall || structstall;
  assign stall_d = stall_e || lwstall || sbstall;
  assign hz.stallM = memstall;
  assign hz.stallE = stall_e;
  assign hz.stallD = stall_d;
  assign hz.stallF = stall_d;
  assign hz.flushD = hz.PCSrcE && !stall_e;
  assign hz.flushE = (lwstall || sbstall || hz.PCSrcE) && !stall_e;
  assign issue = hz.LongIssueE && !stall_e && hz.rdE != '0;
  reg_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .MAX_OUTSTANDING(MAX_OUTSTANDING)) u_sb (
    .clk(clk),
    .reset(reset),
    .issue_i(issue),
    .issue_rd_i(hz.rdE),
    .done_i(hz.LongDoneW),
    .done_rd_i(hz.LongRdW),
    .busy_o(busy),
    .full_o(full)
  );
  assign hz.sb_busy = busy;
  assign stall_cnt_d = (stall_d && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of forwarding, stalls, scoreboard and counter via an expectation queue
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  typedef struct {string tag; logic [63:0] val;} exp_t;
  exp_t q[$];

  hazard_scoreboard_if hz();
  hazard_scoreboard dut (.clk(clk), .reset(reset), .hz(hz));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  function automatic logic [5:0] sv();
    return {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE};
  endfunction

  task automatic ex(input string t, input logic [63:0] v);
    q.push_back('{t, v});
  endtask

  task automatic ck(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL queue_empty observed=%0h expected=none", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.rs1D = '0; hz.rs2D = '0; hz.rs1E = '0; hz.rs2E = '0;
    hz.rdE = '0; hz.rdM = '0; hz.rdW = '0; hz.LongRdW = '0;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.ResultSrcE0 = 0; hz.PCSrcE = 0;
    hz.LongIssueE = 0; hz.LongDoneW = 0; hz.DmemReadyM = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    ex("reset_busy", 0); ex("reset_cnt", 0); ex("reset_ctl", 0);
    #2; ck(hz.sb_busy); ck(hz.stall_cnt); ck(sv());
    // forwarding priority
    hz.rs1E = 5; hz.rdM = 5; hz.RegWriteM = 1; hz.rdW = 5; hz.RegWriteW = 1; hz.rs2E = 0;
    ex("fwd_a_m", 2'b10); ex("fwd_b_x0", 2'b00);
    #1; ck(hz.forwardaE); ck(hz.forwardbE);
    hz.rs1E = 0; hz.RegWriteM = 0; hz.rs2E = 5;
    ex("fwd_a_x0", 2'b00); ex("fwd_b_w", 2'b01);
    #1; ck(hz.forwardaE); ck(hz.forwardbE);
    hz.rs2E = 3;
    ex("fwd_b_none", 2'b00);
    #1; ck(hz.forwardbE);
    // load-use
    idle(); hz.ResultSrcE0 = 1; hz.rdE = 7; hz.rs2D = 7;
    ex("lw_stall", 6'b110001);
    #1; ck(sv());
    hz.rdE = 0;
    ex("lw_x0", 6'b000000);
    #1; ck(sv());
    // scoreboard issue / dependent stall / completion
    tick(); idle(); hz.LongIssueE = 1; hz.rdE = 9;
    ex("issue9_ctl", 6'b000000);
    #1; ck(sv());
    tick(); idle(); hz.rs1D = 9;
    ex("busy9", 64'(32'h1 << 9)); ex("sb_stall", 6'b110001);
    #1; ck(hz.sb_busy); ck(sv());
    tick();
    ex("busy9_hold", 64'(32'h1 << 9)); ex("sb_stall_hold", 6'b110001);
    #1; ck(hz.sb_busy); ck(sv());
    hz.LongDoneW = 1; hz.LongRdW = 9;
    ex("sb_stall_done", 6'b110001);
    #1; ck(sv());
    tick(); hz.LongDoneW = 0;
    ex("busy9_clr", 0); ex("sb_release", 6'b000000);
    #1; ck(hz.sb_busy); ck(sv());
    // structural limit
    idle(); hz.LongIssueE = 1; hz.rdE = 3;
    tick(); hz.rdE = 4;
    tick(); hz.rdE = 6;
    ex("busy34", 64'h18); ex("struct_full", 6'b111000);
    #1; ck(hz.sb_busy); ck(sv());
    tick();
    ex("busy34_hold", 64'h18);
    #1; ck(hz.sb_busy);
    hz.LongDoneW = 1; hz.LongRdW = 3;
    ex("struct_done_same", 6'b111000);
    #1; ck(sv());
    tick(); hz.LongDoneW = 0;
    ex("busy4", 64'h10); ex("issue6_go", 6'b000000);
    #1; ck(hz.sb_busy); ck(sv());
    tick(); hz.rdE = 8;
    ex("busy46", 64'h50); ex("struct_full2", 6'b111000);
    #1; ck(hz.sb_busy); ck(sv());
    hz.LongIssueE = 0; hz.ResultSrcE0 = 1; hz.rdE = 4;
    ex("waw_load", 6'b111000);
    #1; ck(sv());
    hz.rdE = 5;
    ex("load_free", 6'b000000);
    #1; ck(sv());
    idle(); hz.LongDoneW = 1; hz.LongRdW = 4;
    tick(); hz.LongRdW = 6;
    tick(); hz.LongRdW = 10;
    tick(); idle();
    ex("busy_empty", 0);
    #1; ck(hz.sb_busy);
    // memory wait vs branch
    hz.DmemReadyM = 0; hz.PCSrcE = 1;
    ex("mem_wait", 6'b111100);
    #1; ck(sv());
    hz.DmemReadyM = 1;
    ex("branch_flush", 6'b000011);
    #1; ck(sv());
    // stall counter and reset mid long op
    idle(); reset = 1;
    tick(); reset = 0;
    ex("cnt_reset", 0);
    #1; ck(hz.stall_cnt);
    hz.DmemReadyM = 0;
    tick(); tick(); tick(); hz.DmemReadyM = 1;
    ex("cnt3", 3);
    #1; ck(hz.stall_cnt);
    hz.LongIssueE = 1; hz.rdE = 12;
    tick(); idle();
    ex("busy12", 64'(32'h1 << 12));
    #1; ck(hz.sb_busy);
    reset = 1;
    tick(); reset = 0;
    ex("rst_busy", 0); ex("rst_cnt", 0);
    #1; ck(hz.sb_busy); ck(hz.stall_cnt);
    hz.LongDoneW = 1; hz.LongRdW = 12;
    tick(); idle();
    ex("stale_done", 0);
    #1; ck(hz.sb_busy);
    hz.LongIssueE = 1; hz.rdE = 1;
    ex("post_rst_issue1", 6'b000000);
    #1; ck(sv());
    tick(); hz.rdE = 2;
    ex("post_rst_issue2", 6'b000000);
    #1; ck(sv());
    tick(); hz.rdE = 3;
    ex("post_rst_full", 6'b111000);
    #1; ck(sv());
    idle();
    if (q.size() != 0) begin
      errors++;
      $error("FAIL queue_leftover observed=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard unit for the 5-stage RV32I pipeline, generalising the forwarding/stall/flush logic to support multi-cycle (long-latency) writers and a variable-latency data memory.
- A per-register busy scoreboard tracks pending long-op destinations, such as an iterative divider, and stalls dependent instructions in D.
- An outstanding-op counter enforces a structural limit on in-flight long ops.
- A memory-ready input freezes F/D/E/M while the data memory is busy.
- Sits beside the datapath; drives forwarding muxes in E and stall/flush enables of the pipeline registers.

Parameters:
REG_ADDR_W, 5, register index width; register count is 2**REG_ADDR_W.
MAX_OUTSTANDING, 2, maximum in-flight long ops (range 1..2**REG_ADDR_W-1).
STALL_CNT_W, 16, width of stall performance counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
rs1D, rs2D  in  REG_ADDR_W  source registers in D.
rs1E, rs2E, rdE  in  REG_ADDR_W  sources and destination in E.
rdM, rdW  in  REG_ADDR_W  destinations in M and W.
RegWriteM, RegWriteW  in  1  normal register write pending in M and W.
ResultSrcE0  in  1  E holds a load.
PCSrcE  in  1  taken branch/jump resolved in E.
LongIssueE  in  1  E holds a long op writing rdE.
LongDoneW  in  1  a long op writes back this cycle.
LongRdW  in  REG_ADDR_W  destination of the completing long op.
DmemReadyM  in  1  data memory can complete M this cycle.
forwardaE, forwardbE  out  2  forwarding selects: 00 regfile, 01 W, 10 M.
stallF, stallD, stallE, stallM  out  1  hold pipeline register.
flushD, flushE  out  1  bubble pipeline register.
sb_busy  out  2**REG_ADDR_W  scoreboard vector.
stall_cnt  out  STALL_CNT_W  count of cycles with stallF high.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- All stall, flush and forward outputs are combinational and carry no delays. sb_busy and stall_cnt are registered.
- Forwarding:
  - Source index 0 always selects 00.
  - Otherwise a match with rdM & RegWriteM selects 10.
  - Else a match with rdW & RegWriteW selects 01.
  - Else 00.
- Internal stall terms:
  - memstall = ~DmemReadyM.
  - lwstall = ResultSrcE0 & rdE!=0 & (rdE==rs1D | rdE==rs2D).
  - sbstall = (busy[rs1D] & rs1D!=0) | (busy[rs2D] & rs2D!=0).
  - structstall = (LongIssueE & (count==MAX_OUTSTANDING | busy[rdE])) | (RegWriteE-type WAW: E writer with busy[rdE] & rdE!=0). The WAW term uses LongIssueE|ResultSrcE0 as the E-writer qualifier; no other qualifier.
- Stall and flush outputs:
  - stallM = memstall.
  - stallE = memstall | structstall.
  - stallD = stallE | lwstall | sbstall.
  - stallF = stallD.
  - flushD = PCSrcE & ~stallE.
  - flushE = (lwstall | sbstall | PCSrcE) & ~stallE.
- Issue condition: issue = LongIssueE & ~stallE & rdE!=0. Issue sets busy[rdE] at the next edge.
- Completion condition: done = LongDoneW & busy[LongRdW]. Completion clears busy[LongRdW]. A completion to a non-busy register is ignored.
- Simultaneous issue and completion:
  - Same register: set wins, and the count is unchanged.
  - Different registers: both take effect.
- Outstanding count: +1 on issue only, -1 on done only, unchanged when both occur. It never exceeds MAX_OUTSTANDING and never underflows. busy[0] is always 0.
- stall_cnt increments each cycle stallF=1 and saturates at all-ones.
- Reset: busy=0, count=0, stall_cnt=0. Reset mid-operation discards pending long ops; later LongDoneW pulses for them are ignored.

Decomposition:
- Shared package holds:
  - FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - Default REG_ADDR_W.
- Sub-module reg_scoreboard: busy vector, outstanding counter, and the issue/done update rules. It exposes busy and full.
- The top level keeps forwarding and stall/flush combinational logic plus stall_cnt.

Test Plan:
- Forwarding: rs1E=5, rdM=5, RegWriteM=1, rdW=5, RegWriteW=1 -> forwardaE=10. Same with rs1E=0 -> forwardaE=00.
- Load-use: ResultSrcE0=1, rdE=7, rs2D=7 -> stallF=stallD=flushE=1, stallE=0. Same with rdE=0 -> no stall.
- Scoreboard:
  - Issue long op rdE=9 -> next cycle sb_busy[9]=1.
  - rs1D=9 -> stallD=1, flushE=1 until LongDoneW with LongRdW=9. Cycle after completion: busy[9]=0, stall released.
- Structural limit, MAX_OUTSTANDING=2:
  - Issue to x3 and x4 -> third LongIssueE with rdE=6 gives stallE=1 with flushE=0.
  - Completion of x3 -> issue proceeds next cycle, count stays 2.
- Memory wait and branch: DmemReadyM=0 with PCSrcE=1 -> all four stalls=1, flushD=flushE=0. DmemReadyM=1 -> flushD=flushE=1.
- Reset/counter:
  - 3 stall cycles -> stall_cnt=3.
  - Assert reset mid long op -> busy=0 and stall_cnt=0 next edge; a stale LongDoneW leaves count=0.
